// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
// Provides the sequencer FSM state encoding, the hard-wired zero register
// number and the load/store opcodes used by the decoder.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   id_rs, id_rt  - source register fields of the instruction in ID
//   ex_rw         - destination register of the instruction in EX
//   ex_memtoreg   - instruction in EX is a load
//   load_use      - ID reads a register the EX load has not produced yet
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rw,
  input  logic       ex_memtoreg,
  output logic       load_use
);

  // r0 is never written, so a load targeting it cannot create a dependency.
  assign load_use = ex_memtoreg & (ex_rw != REG_ZERO) &
                    ((ex_rw == id_rs) | (ex_rw == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Drives hold/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, resolves
// load-use hazards and taken-branch flushes, and runs the multi-cycle
// data-memory handshake with a timeout.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt      - ID source registers
//   ex_rw             - EX destination register
//   ex_memtoreg       - EX holds a load
//   ex_branch_taken   - branch resolved taken in EX
//   mem_memwr         - store in MEM
//   mem_memtoreg      - load in MEM
//   dmem_ready        - data memory completes this cycle
//   dmem_req          - data memory request
//   pc_hold .. mem_wb_bubble - pipeline register controls
//   mem_err           - sticky memory-timeout flag
//   stall_cnt         - saturating count of cycles with pc_hold=1
//   state             - FSM state (debug)
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             mem_memwr,
  input  logic             mem_memtoreg,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc;
  logic in_wait;
  logic timeout;
  logic freeze;
  logic load_use;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rw       (ex_rw),
    .ex_memtoreg (ex_memtoreg),
    .load_use    (load_use)
  );

  always_comb begin
    mem_acc = mem_memwr | mem_memtoreg;
    in_wait = (state_q == ST_MEM_WAIT);
    timeout = in_wait & (wait_cnt_q == WAIT_LAST) & ~dmem_ready;
    freeze  = mem_acc & ~dmem_ready & ~timeout;
  end

  // Controls are gated by rst_n so a reset mid-access drops the request
  // immediately, without waiting for a clock edge.
  always_comb begin
    dmem_req      = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_err       = 1'b0;
    if (rst_n) begin
      dmem_req = in_wait | mem_acc;
      mem_err  = mem_err_q | timeout;
      if (freeze) begin
        // EX is held too, so branch/load-use get re-evaluated after the freeze.
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        // The ID instruction is squashed, so its load-use hazard is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state     = state_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q | timeout;
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_RUN: begin
        if (mem_acc & ~dmem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request is treated as completion rather than hanging.
        if (dmem_ready | timeout | ~mem_acc) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MAXW  = 4;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rw;
  logic          ex_memtoreg, ex_branch_taken, mem_memwr, mem_memtoreg, dmem_ready;
  logic          dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic          ex_mem_hold, mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles the current memory access has already been frozen,
  // sticky error, and the saturating stall count.
  int m_waited = 0;
  bit m_err    = 1'b0;
  int m_stall  = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rw(ex_rw),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold,
            id_ex_flush, ex_mem_hold, mem_wb_bubble, mem_err};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rw = 5'd0;
    ex_memtoreg = 1'b0; ex_branch_taken = 1'b0;
    mem_memwr = 1'b0; mem_memtoreg = 1'b0; dmem_ready = 1'b0;
  endtask

  // Check one cycle at the falling edge, then advance the model to the next
  // rising edge. Returns just after that rising edge.
  task automatic cycle();
    logic [8:0] e;
    bit macc, inw, tmo, frz, lu, pch;
    @(negedge clk);
    macc = mem_memwr | mem_memtoreg;
    inw  = (m_waited > 0);
    tmo  = inw && (m_waited == MAXW - 1) && !dmem_ready;
    frz  = macc && !dmem_ready && !tmo;
    lu   = ex_memtoreg && (ex_rw != 0) && ((ex_rw == id_rs) || (ex_rw == id_rt));
    e    = '0;
    e[8] = inw || macc;
    if (frz) begin
      e[7] = 1'b1; e[6] = 1'b1; e[4] = 1'b1; e[2] = 1'b1; e[1] = 1'b1;
    end else if (ex_branch_taken) begin
      e[5] = 1'b1; e[3] = 1'b1;
    end else if (lu) begin
      e[7] = 1'b1; e[6] = 1'b1; e[3] = 1'b1;
    end
    e[0] = m_err || tmo;
    pch  = e[7];
    check_eq("ctrl", 32'(ctrl_vec()), 32'(e));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check_eq("state", 32'(state), inw ? 32'd1 : 32'd0);
    m_err = m_err || tmo;
    if (pch && m_stall < SAT) m_stall++;
    m_waited = frz ? m_waited + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with hazard-provoking inputs: everything must still read 0.
    rst_n = 1'b0;
    idle();
    mem_memwr = 1'b1; ex_branch_taken = 1'b1;
    ex_memtoreg = 1'b1; ex_rw = 5'd7; id_rs = 5'd7;
    #12;
    check_eq("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    check_eq("reset_stall", 32'(stall_cnt), 32'd0);
    check_eq("reset_state", 32'(state), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: one stall cycle, then the load moves on.
    ex_memtoreg = 1'b1; ex_rw = 5'd5; id_rs = 5'd5;
    cycle();
    idle();
    cycle();
    check_eq("tp1_stall", 32'(stall_cnt), 32'd1);
    // Load into r0 is not a hazard.
    ex_memtoreg = 1'b1; ex_rw = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cycle();

    // Branch taken together with a load-use hazard: flush wins.
    idle();
    ex_memtoreg = 1'b1; ex_rw = 5'd9; id_rt = 5'd9; ex_branch_taken = 1'b1;
    cycle();
    check_eq("tp2_stall", 32'(stall_cnt), 32'd1);

    // Memory wait: three cycles not ready, then ready.
    idle();
    mem_memtoreg = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    dmem_ready = 1'b1;
    cycle();
    idle();
    cycle();
    check_eq("tp3_stall", 32'(stall_cnt), 32'd4);

    // Zero-wait store.
    mem_memwr = 1'b1; dmem_ready = 1'b1;
    cycle();
    idle();

    // Timeout with ready held low.
    mem_memtoreg = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    idle();
    cycle();
    check_eq("tp5_err", 32'(mem_err), 32'd1);
    check_eq("tp5_stall", 32'(stall_cnt), 32'd7);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rw           = 5'($urandom_range(0, 3));
      ex_memtoreg     = ($urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_memwr       = ($urandom_range(0, 4) == 0);
      mem_memtoreg    = ($urandom_range(0, 3) == 0);
      dmem_ready      = ($urandom_range(0, 9) < ((i < 750) ? 5 : 2));
      cycle();
    end

    // Reset in the middle of a memory wait.
    idle();
    mem_memtoreg = 1'b1;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("tp6_ctrl", 32'(ctrl_vec()), 32'd0);
    check_eq("tp6_stall", 32'(stall_cnt), 32'd0);
    m_waited = 0; m_err = 1'b0; m_stall = 0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    check_eq("tp6_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
